// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues in-order imem reads and buffers the returned words in a FIFO.
// Optional build macro IFU_STATS_EN adds the stat_fetched / stat_flushed counter outputs.
module inst_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IFU_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  // state   | meaning
  // S_FETCH | issuing requests under the credit limit, responses go into the FIFO
  // S_FLUSH | draining responses to requests made before a redirect, nothing issued

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          run_q;
  logic [31:0]   fpc_q, fpc_d;
  logic [AW:0]   outst_q, outst_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];

  logic          req_fire;
  logic          rsp_take;
  logic          push;
  logic          pop;
  logic          credit_ok;
  logic          head_from_push;
  logic [31:0]   rsp_pc;

  // Outstanding requests are always a contiguous run ending just below fpc, so the
  // oldest one (the one this response answers) sits outstanding*4 bytes back.
  assign rsp_pc    = fpc_q - 32'({outst_q, 2'b00});
  assign credit_ok = (32'(count_q) + 32'(outst_q)) < 32'(DEPTH);

  assign imem_req_valid = run_q && (state_q == S_FETCH) && !redirect && credit_ok;
  assign imem_req_addr  = fpc_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = inst_q;
  assign inst_pc        = pc_q;

  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (outst_q != '0);
  assign pop            = inst_valid && inst_ready;
  assign push           = rsp_take && (state_q == S_FETCH) && !redirect;
  assign head_from_push = push && (count_q == (AW+1)'(pop));

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    outst_d  = outst_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    if (redirect) begin
      fpc_d    = redirect_pc & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      outst_d  = outst_q - (AW+1)'(rsp_take);
      state_d  = (outst_d != '0) ? S_FLUSH : S_FETCH;
    end else begin
      if (req_fire) begin
        fpc_d = fpc_q + 32'd4;
      end
      outst_d = outst_q + (AW+1)'(req_fire) - (AW+1)'(rsp_take);
      if ((state_q == S_FLUSH) && (outst_d == '0)) begin
        state_d = S_FETCH;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      // Head register tracks the FIFO head and simply holds once the FIFO drains.
      if (count_d != '0) begin
        if (head_from_push) begin
          inst_d = imem_rsp_data;
          pc_d   = rsp_pc;
        end else begin
          inst_d = mem_inst_q[rd_ptr_d];
          pc_d   = mem_pc_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      run_q    <= 1'b0;
      fpc_q    <= RESET_PC;
      outst_q  <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      inst_q   <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      fpc_q    <= fpc_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= imem_rsp_data;
      mem_pc_q[wr_ptr_q]   <= rsp_pc;
    end
  end

`ifdef IFU_STATS_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_flushed_q;
  logic [31:0] flushed_inc;

  // A redirect throws away the unconsumed FIFO entries plus any response landing that cycle.
  always_comb begin
    flushed_inc = '0;
    if (redirect) begin
      flushed_inc = 32'(count_q) - 32'(pop) + 32'(rsp_take);
    end else if (state_q == S_FLUSH) begin
      flushed_inc = 32'(rsp_take);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_q + 32'(push);
      stat_flushed_q <= stat_flushed_q + flushed_inc;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule
